dpram_rd_ctrl: RTL and testbench
================================

DPRAM_RD_CTRL -- requirements
Module: dpram_rd_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the RAM word width and stream data width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, meaning the RAM address width; depth is 2**ADDRESS_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to read one frame.
REQ-006 The block SHALL have port base_addr, input, ADDRESS_WIDTH bits: the first RAM address of the frame, sampled with start.
REQ-007 The block SHALL have port len, input, ADDRESS_WIDTH+1 bits: the frame length in words (0..2**ADDRESS_WIDTH), sampled with start.
REQ-008 The block SHALL have ports reb (output, 1), addrb (output, ADDRESS_WIDTH) and doutb (input, DATA_WIDTH): the RAM read port; data is valid one cycle after reb.
REQ-009 The block SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_WIDTH) and m_last (output, 1): the output stream.
REQ-010 The block SHALL have ports busy (output, 1), high while a frame is in progress, and done (output, 1), a one-cycle pulse at frame end.

Function
REQ-011 The FSM SHALL have the states IDLE, READ and DRAIN.
REQ-012 In IDLE, start SHALL capture base_addr and len and enter READ when len>0; start is ignored outside IDLE.
REQ-013 A start with len=0 SHALL issue no reads, stay in IDLE, and pulse done on the next cycle.
REQ-014 In READ, reb SHALL assert only when (reads in flight + words in the output buffer) < 2.
REQ-015 The 2-entry output buffer SHALL ensure no word is dropped or duplicated under any m_ready pattern.
REQ-016 addrb SHALL start at base_addr and increment by 1 per issued read, wrapping modulo 2**ADDRESS_WIDTH.
REQ-017 After issuing len reads, the FSM SHALL enter DRAIN.
REQ-018 DRAIN SHALL return to IDLE on the cycle the last word is accepted (m_valid && m_ready && m_last); done SHALL pulse in that same cycle.
REQ-019 m_last SHALL be high only with the len-th word of a frame.
REQ-020 m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-021 With m_ready held at 1, the latency from start to the first m_valid SHALL be 2 cycles, and throughput SHALL be 1 word per cycle.
REQ-022 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE.

Reset
REQ-023 While rst_n=0, the FSM SHALL be in IDLE, the buffer SHALL be empty, and reb, m_valid, m_last, busy and done SHALL be 0; addrb and m_data SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL discard the frame and any in-flight read; no done pulse SHALL follow.

Configuration
REQ-025 With macro DPRAM_RD_CTRL_ABORT_EN defined, the block SHALL add input abort (1 bit).
REQ-026 With DPRAM_RD_CTRL_ABORT_EN defined, abort=1 in READ or DRAIN SHALL stop new reads, flush the buffer, drop any in-flight word, and return to IDLE next cycle with done=0.
REQ-027 Without DPRAM_RD_CTRL_ABORT_EN, the abort port SHALL not exist and frames SHALL always complete.

Verification
REQ-028 base_addr=3, len=4, m_ready=1 -> addrb 3,4,5,6; m_data RAM[3..6] on consecutive cycles, first 2 cycles after start; m_last with RAM[6]; done at the same cycle.
REQ-029 base_addr=30, len=5 (ADDRESS_WIDTH=5) -> addrb 30,31,0,1,2; m_last with RAM[2].
REQ-030 len=8 with m_ready toggling 1,0,0,1 repeating -> exactly 8 words in order; reb never leaves more than 2 words outstanding or buffered.
REQ-031 len=0 -> no reb, done pulse 1 cycle after start; start while busy -> ignored and the frame is unaffected.
REQ-032 rst_n=0 asserted after 3 of len=10 words -> all outputs 0 immediately; the next start with len=2 -> 2 clean words.
REQ-033 With DPRAM_RD_CTRL_ABORT_EN, abort after 2 of len=6 words -> IDLE next cycle, m_valid=0, no done; a new start works normally.

Source files
------------

// File: rtl/dpram_rd_ctrl.sv
// Reads a frame of len words from a dual-port RAM read port and streams it out through a 2-entry buffer.
// Optional abort input is enabled by defining DPRAM_RD_CTRL_ABORT_EN.
module dpram_rd_ctrl #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [ADDRESS_WIDTH:0]   len,
   output logic                     reb,
   output logic [ADDRESS_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0]    doutb,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic                     done
`ifdef DPRAM_RD_CTRL_ABORT_EN
   ,
   input  logic                     abort
`endif
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [ADDRESS_WIDTH:0] LEN_ONE = 1;

   state_t                   r_state;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [ADDRESS_WIDTH:0]   r_rd_left;
   logic                     r_inflight;
   logic                     r_inflight_last;
   logic [DATA_WIDTH-1:0]    r_buf_data [2];
   logic [1:0]               r_buf_last;
   logic                     r_wr_ptr;
   logic                     r_rd_ptr;
   logic [1:0]               r_count;
   logic                     r_done_zero;

   logic                     w_abort;
   logic [1:0]               w_occupancy;
   logic                     w_issue;
   logic                     w_accept;
   logic                     w_push;
   logic                     w_pop;

`ifdef DPRAM_RD_CTRL_ABORT_EN
   assign w_abort = abort && (r_state != IDLE);
`else
   assign w_abort = 1'b0;
`endif

   // A read may only be issued if its word is guaranteed a buffer slot.
   assign w_occupancy = {1'b0, r_inflight} + r_count;
   assign w_issue     = (r_state == READ) && !w_abort && (w_occupancy < 2'd2);

   // An in-flight word is presented directly when the buffer is empty, which gives 2-cycle latency.
   assign m_valid  = !w_abort && ((r_count != 2'd0) || r_inflight);
   assign w_accept = m_valid && m_ready;
   assign w_push   = r_inflight && !((r_count == 2'd0) && w_accept);
   assign w_pop    = (r_count != 2'd0) && w_accept;

   always_comb begin
      m_data = '0;
      m_last = 1'b0;
      if (r_count != 2'd0) begin
         m_data = r_buf_data[r_rd_ptr];
         m_last = r_buf_last[r_rd_ptr];
      end else if (r_inflight) begin
         m_data = doutb;
         m_last = r_inflight_last;
      end
   end

   assign reb   = w_issue;
   assign addrb = r_addr;
   assign busy  = (r_state != IDLE);
   assign done  = r_done_zero || ((r_state == DRAIN) && w_accept && m_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_addr          <= '0;
         r_rd_left       <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_buf_last      <= '0;
         r_wr_ptr        <= 1'b0;
         r_rd_ptr        <= 1'b0;
         r_count         <= '0;
         r_done_zero     <= 1'b0;
      end else begin
         r_done_zero     <= (r_state == IDLE) && start && (len == '0);
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_rd_left == LEN_ONE);

         if (w_issue) begin
            r_addr    <= r_addr + 1'b1;
            r_rd_left <= r_rd_left - 1'b1;
         end

         if (w_abort) begin
            r_count  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
         end else begin
            if (w_push) begin
               r_buf_last[r_wr_ptr] <= r_inflight_last;
               r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end

         case (r_state)
            IDLE: begin
               if (start && (len != '0)) begin
                  r_addr    <= base_addr;
                  r_rd_left <= len;
                  r_state   <= READ;
               end
            end
            READ: begin
               if (w_abort) begin
                  r_state <= IDLE;
               end else if (w_issue && (r_rd_left == LEN_ONE)) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_abort || (w_accept && m_last)) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // NOTE: buffer payload is not reset; the occupancy count alone decides validity, so reset stays off the wide datapath.
   always_ff @(posedge clk) begin
      if (w_push && !w_abort) begin
         r_buf_data[r_wr_ptr] <= doutb;
      end
   end

endmodule

// File: tb/tb_dpram_rd_ctrl.sv
// Directed self-checking bench for dpram_rd_ctrl with a behavioural synchronous RAM read port.
// Abort scenario is compiled in when DPRAM_RD_CTRL_ABORT_EN is defined.
module tb_dpram_rd_ctrl;

   localparam int DW = 16;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          reb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          done;
   logic          abort = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   dpram_rd_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .reb       (reb),
      .addrb     (addrb),
      .doutb     (doutb),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .done      (done)
`ifdef DPRAM_RD_CTRL_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ram_val(input int a);
      return 16'hA000 | 16'(a * 17);
   endfunction

   always @(posedge clk) begin
      if (reb) doutb <= ram_val(int'(addrb));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] q_data [$];
   logic          q_last [$];
   int            q_cyc  [$];
   logic [AW-1:0] q_addr [$];
   int            q_done [$];
   int            n_iss = 0;
   int            n_acc = 0;
   int            max_out = 0;
   int            stall_viol = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   // Observes the DUT mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n || abort) begin
         prev_stall <= 1'b0;
         n_iss      <= 0;
         n_acc      <= 0;
      end else begin
         if (reb) q_addr.push_back(addrb);
         if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_last.push_back(m_last);
            q_cyc.push_back(cyc);
         end
         if (done) q_done.push_back(cyc);
         if (n_iss + int'(reb) - n_acc > max_out) max_out <= n_iss + int'(reb) - n_acc;
         n_iss <= n_iss + int'(reb);
         n_acc <= n_acc + int'(m_valid && m_ready);
         if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
            stall_viol <= stall_viol + 1;
         prev_stall <= m_valid && !m_ready;
         prev_data  <= m_data;
         prev_last  <= m_last;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ready_pat(input int k);
      return (k % 4 == 0) || (k % 4 == 3);
   endfunction

   int f_w0, f_a0, f_d0, f_start_cyc;

   // Runs one frame; optionally toggles m_ready and pokes start while busy.
   task automatic run_frame(input string tag, input int base, input int n, input bit toggle, input bit poke);
      int k;
      f_w0 = q_data.size();
      f_a0 = q_addr.size();
      f_d0 = q_done.size();
      m_ready     = toggle ? ready_pat(0) : 1'b1;
      base_addr   = AW'(base);
      len         = (AW+1)'(n);
      start       = 1'b1;
      f_start_cyc = cyc;
      tick();
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'(n != 0));
      k = 1;
      while (q_done.size() == f_d0 && k < 200) begin
         m_ready = toggle ? ready_pat(k) : 1'b1;
         if (poke && k == 2) begin
            start = 1'b1; base_addr = '0; len = 2;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      m_ready = 1'b1;
      repeat (3) tick();
      check({tag, "_done_count"}, 32'(q_done.size() - f_d0), 32'd1);
      check({tag, "_word_count"}, 32'(q_data.size() - f_w0), 32'(n));
      check({tag, "_read_count"}, 32'(q_addr.size() - f_a0), 32'(n));
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
      if (q_data.size() - f_w0 == n && q_addr.size() - f_a0 == n) begin
         for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[f_a0+i]), 32'((base + i) % 32));
            check($sformatf("%s_data%0d", tag, i), 32'(q_data[f_w0+i]), 32'(ram_val((base + i) % 32)));
            check($sformatf("%s_last%0d", tag, i), 32'(q_last[f_w0+i]), 32'(i == n - 1));
         end
         if (n > 0 && q_done.size() > f_d0)
            check({tag, "_done_with_last"}, 32'(q_done[f_d0]), 32'(q_cyc[f_w0+n-1]));
      end
   endtask

   initial begin
      int k;
      int d0;
      int w0;

      // Reset state
      repeat (2) tick();
      check("rst_ctrl", 32'({reb, m_valid, m_last, busy, done}), 32'd0);
      check("rst_addrb", 32'(addrb), 32'd0);
      check("rst_mdata", 32'(m_data), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // base 3, len 4, full throughput
      run_frame("f28", 3, 4, 1'b0, 1'b0);
      if (q_data.size() - f_w0 == 4) begin
         check("f28_first_latency", 32'(q_cyc[f_w0] - f_start_cyc), 32'd2);
         check("f28_back_to_back", 32'(q_cyc[f_w0+3] - q_cyc[f_w0]), 32'd3);
      end

      // Address wrap
      run_frame("f29", 30, 5, 1'b0, 1'b0);

      // Backpressure 1,0,0,1
      run_frame("f30", 9, 8, 1'b1, 1'b0);

      // Zero-length frame
      run_frame("len0", 17, 0, 1'b0, 1'b0);
      if (q_done.size() > f_d0)
         check("len0_done_cycle", 32'(q_done[f_d0] - f_start_cyc), 32'd1);

      // Start while busy is ignored
      run_frame("poke", 10, 4, 1'b0, 1'b1);

      // Reset mid-frame
      w0 = q_data.size();
      m_ready = 1'b1; base_addr = 12; len = 10; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (q_data.size() - w0 < 3 && k < 50) begin
         tick();
         k++;
      end
      check("midrst_reached3", 32'(q_data.size() - w0), 32'd3);
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl", 32'({reb, m_valid, m_last, busy, done}), 32'd0);
      check("midrst_addrb", 32'(addrb), 32'd0);
      check("midrst_mdata", 32'(m_data), 32'd0);
      d0 = q_done.size();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("midrst_no_done", 32'(q_done.size() - d0), 32'd0);
      run_frame("postrst", 7, 2, 1'b0, 1'b0);

`ifdef DPRAM_RD_CTRL_ABORT_EN
      // Abort after 2 of 6 words
      w0 = q_data.size();
      d0 = q_done.size();
      m_ready = 1'b1; base_addr = 20; len = 6; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (q_data.size() - w0 < 2 && k < 50) begin
         tick();
         k++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mvalid", 32'(m_valid), 32'd0);
      repeat (3) tick();
      check("abort_words", 32'(q_data.size() - w0), 32'd2);
      check("abort_no_done", 32'(q_done.size() - d0), 32'd0);
      run_frame("postabort", 1, 3, 1'b0, 1'b0);
`endif

      check("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
      check("stall_stability", 32'(stall_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
